// File: rtl/fir_seq_if.sv
// Band-queue / coefficient-ROM / result bus for one equalizer band sequencer.
// Handshake: 'sequencing' acts as a valid with no ready. Every cycle it is high
// carries one sample pair, and the sequencer always accepts it. 'vld' and 'err'
// are single-cycle strobes to the downstream stage, which cannot stall them.
interface fir_seq_if #(
    parameter int ADDR_W = 10
);
    logic              sequencing;
    logic [15:0]       lft_smpl;
    logic [15:0]       rght_smpl;
    logic [ADDR_W-1:0] coeff_addr;
    logic [15:0]       coeff;
    logic [15:0]       lft_out;
    logic [15:0]       rght_out;
    logic              vld;
    logic              err;
    logic              busy;

    // Sequencer side
    modport slave (
        input  sequencing, lft_smpl, rght_smpl, coeff,
        output coeff_addr, lft_out, rght_out, vld, err, busy
    );

    // Queue / ROM / downstream side
    modport master (
        output sequencing, lft_smpl, rght_smpl, coeff,
        input  coeff_addr, lft_out, rght_out, vld, err, busy
    );
endinterface

// File: rtl/fir_seq_ctrl.sv
// Tap sequencer and stereo MAC for one equalizer band.
// Walks the coefficient ROM in step with the incoming sample stream,
// accumulates sample*coeff per channel, and after the stream ends emits one
// saturated 16-bit result per channel (vld), or err if the run length was wrong.
module fir_seq_ctrl #(
    parameter int TAPS   = 1021,
    parameter int ADDR_W = 10,
    parameter int ACC_W  = 42
) (
    input  logic        clk,
    input  logic        rst_n,
    fir_seq_if.slave    bus,
    output logic [1:0]  dbg_state_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0]       LAST_ADDR = ADDR_W'(TAPS - 1);
    localparam logic [ADDR_W:0]         RUN_LEN   = (ADDR_W + 1)'(TAPS);
    localparam logic signed [ACC_W-1:0] SAT_MAX   = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN   = -SAT_MAX - 1;

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W:0]    len_q, len_d;
    logic               drain_q, drain_d;

    // Stage A: captured samples; stage B: products
    logic               a_vld_q, a_first_q;
    logic signed [15:0] a_l_q, a_r_q;
    logic               b_vld_q, b_first_q;
    logic signed [31:0] b_l_q, b_r_q;
    logic signed [ACC_W-1:0] acc_l_q, acc_r_q;

    logic        vld_q, err_q, busy_q;
    logic [15:0] lft_q, rght_q;

    logic        take;
    logic        len_ok;
    logic signed [ACC_W-1:0] prod_l_ext, prod_r_ext;

    // A sample is consumed only while idle or running; DRAIN/DONE ignore the stream
    assign take   = bus.sequencing && ((state_q == S_IDLE) || (state_q == S_RUN));
    assign len_ok = (len_q == RUN_LEN);

    assign prod_l_ext = {{(ACC_W-32){b_l_q[31]}}, b_l_q};
    assign prod_r_ext = {{(ACC_W-32){b_r_q[31]}}, b_r_q};

    // Arithmetic shift down to Q15 and clamp to the signed 16-bit range
    function automatic logic [15:0] sat16(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> 15;
        if (s > SAT_MAX)      sat16 = 16'h7FFF;
        else if (s < SAT_MIN) sat16 = 16'h8000;
        else                  sat16 = s[15:0];
    endfunction

    // Next-state logic: FSM, saturating tap address, saturating run length
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (bus.sequencing) begin
                    state_d = S_RUN;
                    len_d   = (ADDR_W + 1)'(1);
                    addr_d  = (addr_q == LAST_ADDR) ? addr_q : addr_q + 1'b1;
                end
            end
            S_RUN: begin
                if (bus.sequencing) begin
                    addr_d = (addr_q == LAST_ADDR) ? addr_q : addr_q + 1'b1;
                    len_d  = (&len_q) ? len_q : len_q + 1'b1;
                end else begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end
            end
            S_DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
            end
        endcase
    end

    // Control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            drain_q <= drain_d;
        end
    end

    // Two-stage multiply pipeline and accumulators; the first product loads the accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_vld_q   <= 1'b0;
            a_first_q <= 1'b0;
            a_l_q     <= '0;
            a_r_q     <= '0;
            b_vld_q   <= 1'b0;
            b_first_q <= 1'b0;
            b_l_q     <= '0;
            b_r_q     <= '0;
            acc_l_q   <= '0;
            acc_r_q   <= '0;
        end else begin
            a_vld_q   <= take;
            a_first_q <= take && (state_q == S_IDLE);
            if (take) begin
                a_l_q <= $signed(bus.lft_smpl);
                a_r_q <= $signed(bus.rght_smpl);
            end
            b_vld_q   <= a_vld_q;
            b_first_q <= a_first_q;
            b_l_q     <= a_l_q * $signed(bus.coeff);
            b_r_q     <= a_r_q * $signed(bus.coeff);
            if (b_vld_q) begin
                acc_l_q <= (b_first_q ? '0 : acc_l_q) + prod_l_ext;
                acc_r_q <= (b_first_q ? '0 : acc_r_q) + prod_r_ext;
            end
        end
    end

    // Result registers and status strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
            lft_q  <= '0;
            rght_q <= '0;
        end else begin
            vld_q  <= (state_q == S_DONE) && len_ok;
            err_q  <= (state_q == S_DONE) && !len_ok;
            busy_q <= (state_d != S_IDLE) || (state_q == S_DONE);
            if ((state_q == S_DONE) && len_ok) begin
                lft_q  <= sat16(acc_l_q);
                rght_q <= sat16(acc_r_q);
            end
        end
    end

    assign bus.coeff_addr = addr_q;
    assign bus.lft_out    = lft_q;
    assign bus.rght_out   = rght_q;
    assign bus.vld        = vld_q;
    assign bus.err        = err_q;
    assign bus.busy       = busy_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl: a 4-tap instance for the functional scenarios and a
// 1021-tap instance for the full-length impulse and back-to-back runs.
module tb_fir_seq_ctrl;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    fir_seq_if #(.ADDR_W(2))  if4 ();
    fir_seq_if #(.ADDR_W(10)) ifb ();
    logic [1:0] dbg4, dbgb;

    fir_seq_ctrl #(.TAPS(4), .ADDR_W(2), .ACC_W(42)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(if4), .dbg_state_o(dbg4));
    fir_seq_ctrl #(.TAPS(1021), .ADDR_W(10), .ACC_W(42)) dutb (
        .clk(clk), .rst_n(rst_n), .bus(ifb), .dbg_state_o(dbgb));

    // stimulus routed to one instance at a time
    logic        seq = 1'b0;
    logic        sel = 1'b0;
    logic [15:0] l_in = '0, r_in = '0;
    assign if4.sequencing = seq & ~sel;
    assign ifb.sequencing = seq & sel;
    assign if4.lft_smpl   = l_in;
    assign if4.rght_smpl  = r_in;
    assign ifb.lft_smpl   = l_in;
    assign ifb.rght_smpl  = r_in;

    // registered coefficient ROMs
    logic [15:0] rom4 [4];
    logic [15:0] romb [1024];
    always @(posedge clk) begin
        if4.coeff <= rom4[if4.coeff_addr];
        ifb.coeff <= romb[ifb.coeff_addr];
    end

    // observation of the selected instance
    logic [9:0]  o_addr;
    logic [15:0] o_l, o_r;
    logic        o_vld, o_err, o_busy;
    assign o_addr = sel ? ifb.coeff_addr : {8'd0, if4.coeff_addr};
    assign o_l    = sel ? ifb.lft_out  : if4.lft_out;
    assign o_r    = sel ? ifb.rght_out : if4.rght_out;
    assign o_vld  = sel ? ifb.vld  : if4.vld;
    assign o_err  = sel ? ifb.err  : if4.err;
    assign o_busy = sel ? ifb.busy : if4.busy;

    // ---------------- stimulus buffers and run observations ----------------
    logic [15:0] sl [2048];
    logic [15:0] sr [2048];
    logic [15:0] hold_l [2];
    logic [15:0] hold_r [2];
    int p_addr [2048];
    int v_cyc, e_cyc, nv, ne, addr_max, addr_end;
    logic b_first, b_last, b_after;

    // ---------------- reference model ----------------
    function automatic logic [15:0] sat_ref(input longint a);
        longint q;
        q = a >>> 15;
        if (q > 32767)  return 16'h7FFF;
        if (q < -32768) return 16'h8000;
        return q[15:0];
    endfunction

    function automatic logic [15:0] rom_val(input logic s, input int k);
        return s ? romb[k] : rom4[k];
    endfunction

    // A run of exactly TAPS samples gives sum(sample[k]*coeff[k]) in Q15;
    // any other length is an error and leaves the held outputs alone.
    task automatic model_run(input logic s, input int len,
                             output logic [15:0] el, output logic [15:0] er, output logic ok);
        int taps;
        longint al, ar;
        taps = s ? 1021 : 4;
        al = 0;
        ar = 0;
        for (int k = 0; k < taps && k < len; k++) begin
            al += longint'(shortint'(sl[k])) * longint'(shortint'(rom_val(s, k)));
            ar += longint'(shortint'(sr[k])) * longint'(shortint'(rom_val(s, k)));
        end
        ok = (len == taps);
        if (ok) begin
            el = sat_ref(al);
            er = sat_ref(ar);
        end else begin
            el = hold_l[s];
            er = hold_r[s];
        end
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge. Cycle k = the k-th rising edge with sequencing high.
    task automatic drive_run(input logic s, input int len);
        sel = s;
        nv = 0; ne = 0; v_cyc = -1; e_cyc = -1; addr_max = 0;
        seq = 1'b1; l_in = sl[0]; r_in = sr[0];
        for (int k = 0; k < len; k++) begin
            p_addr[k] = int'(o_addr);
            if (int'(o_addr) > addr_max) addr_max = int'(o_addr);
            @(negedge clk);
            if (k == 0) b_first = o_busy;
            if (o_vld) begin nv++; v_cyc = k; end
            if (o_err) begin ne++; e_cyc = k; end
            if (k + 1 < len) begin
                l_in = sl[k+1]; r_in = sr[k+1];
            end else begin
                seq = 1'b0;
            end
        end
        for (int c = len; c <= len + 4; c++) begin
            @(negedge clk);
            if (int'(o_addr) > addr_max) addr_max = int'(o_addr);
            if (o_vld) begin nv++; v_cyc = c; end
            if (o_err) begin ne++; e_cyc = c; end
            if (c == len + 3) b_last  = o_busy;
            if (c == len + 4) b_after = o_busy;
        end
        addr_end = int'(o_addr);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        n_cmp++; if ({if4.coeff_addr, if4.lft_out, if4.rght_out} !== 34'd0) begin n_bad++;
            $display("FAIL reset_data4: got addr=%0h l=%h r=%h, want all 0", if4.coeff_addr, if4.lft_out, if4.rght_out); end
        n_cmp++; if ({if4.vld, if4.err, if4.busy, ifb.vld, ifb.err, ifb.busy} !== 6'd0) begin n_bad++;
            $display("FAIL reset_strobes: got %b%b%b %b%b%b, want 000 000", if4.vld, if4.err, if4.busy, ifb.vld, ifb.err, ifb.busy); end
        n_cmp++; if ({ifb.coeff_addr, ifb.lft_out, ifb.rght_out} !== 42'd0) begin n_bad++;
            $display("FAIL reset_datab: got addr=%0h l=%h r=%h, want all 0", ifb.coeff_addr, ifb.lft_out, ifb.rght_out); end
        hold_l[0] = '0; hold_r[0] = '0; hold_l[1] = '0; hold_r[1] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic(input string tag);
        logic [15:0] el, er;
        logic ok;
        int bad_addr;
        for (int k = 0; k < 4; k++) begin sl[k] = 16'h1000; sr[k] = 16'hF000; rom4[k] = 16'h4000; end
        model_run(1'b0, 4, el, er, ok);
        drive_run(1'b0, 4);
        n_cmp++; if (v_cyc !== 7 || nv !== 1 || ne !== 0) begin n_bad++;
            $display("FAIL %s_vld: got vld cycle %0d (n=%0d, err n=%0d), want cycle 7 once, no err", tag, v_cyc, nv, ne); end
        n_cmp++; if (o_l !== el || o_r !== er) begin n_bad++;
            $display("FAIL %s_result: got l=%h r=%h, want l=%h r=%h", tag, o_l, o_r, el, er); end
        n_cmp++; if (o_l !== 16'h2000 || o_r !== 16'hE000) begin n_bad++;
            $display("FAIL %s_known: got l=%h r=%h, want l=2000 r=e000", tag, o_l, o_r); end
        bad_addr = 0;
        for (int k = 0; k < 4; k++) if (p_addr[k] != k) bad_addr++;
        n_cmp++; if (bad_addr != 0 || addr_end != 0) begin n_bad++;
            $display("FAIL %s_addr_seq: got %0d,%0d,%0d,%0d then %0d, want 0,1,2,3 then 0", tag, p_addr[0], p_addr[1], p_addr[2], p_addr[3], addr_end); end
        n_cmp++; if ({b_first, b_last, b_after} !== 3'b110) begin n_bad++;
            $display("FAIL %s_busy: got first/last/after=%b%b%b, want 110", tag, b_first, b_last, b_after); end
        hold_l[0] = el; hold_r[0] = er;
    endtask

    task automatic test_saturate();
        logic [15:0] el, er;
        logic ok;
        for (int k = 0; k < 4; k++) begin sl[k] = 16'h7FFF; sr[k] = 16'h8000; rom4[k] = 16'h7FFF; end
        model_run(1'b0, 4, el, er, ok);
        drive_run(1'b0, 4);
        n_cmp++; if (nv !== 1 || v_cyc !== 7) begin n_bad++;
            $display("FAIL sat_vld: got vld cycle %0d n=%0d, want cycle 7 once", v_cyc, nv); end
        n_cmp++; if (o_l !== 16'h7FFF || o_r !== 16'h8000 || o_l !== el || o_r !== er) begin n_bad++;
            $display("FAIL sat_result: got l=%h r=%h, want l=7fff r=8000", o_l, o_r); end
        hold_l[0] = el; hold_r[0] = er;
    endtask

    task automatic test_bad_length(input string tag, input int len);
        logic [15:0] el, er;
        logic ok;
        for (int k = 0; k < len; k++) begin sl[k] = 16'($urandom); sr[k] = 16'($urandom); end
        model_run(1'b0, len, el, er, ok);
        drive_run(1'b0, len);
        n_cmp++; if (ne !== 1 || e_cyc !== len + 3 || nv !== 0) begin n_bad++;
            $display("FAIL %s_err: got err cycle %0d n=%0d vld n=%0d, want err cycle %0d once, no vld", tag, e_cyc, ne, nv, len + 3); end
        n_cmp++; if (o_l !== el || o_r !== er) begin n_bad++;
            $display("FAIL %s_hold: got l=%h r=%h, want l=%h r=%h", tag, o_l, o_r, el, er); end
        n_cmp++; if (addr_max > 3 || addr_end != 0 || p_addr[len-1] != ((len - 1 > 3) ? 3 : len - 1)) begin n_bad++;
            $display("FAIL %s_addr: got max=%0d last=%0d end=%0d, want max<=3 end=0", tag, addr_max, p_addr[len-1], addr_end); end
    endtask

    task automatic test_reset_mid_run();
        int pulses;
        sel = 1'b0;
        seq = 1'b1; l_in = 16'h1234; r_in = 16'h4321;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({if4.coeff_addr, if4.lft_out, if4.rght_out, if4.vld, if4.err, if4.busy} !== 37'd0) begin n_bad++;
            $display("FAIL midrst_async: got addr=%0h l=%h r=%h v/e/b=%b%b%b, want all 0",
                     if4.coeff_addr, if4.lft_out, if4.rght_out, if4.vld, if4.err, if4.busy); end
        seq = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        hold_l[0] = '0; hold_r[0] = '0; hold_l[1] = '0; hold_r[1] = '0;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (if4.vld || if4.err) pulses++;
        end
        n_cmp++; if (pulses != 0) begin n_bad++;
            $display("FAIL midrst_no_pulse: got %0d strobes after abort, want 0", pulses); end
        test_basic("post_reset");
    endtask

    task automatic test_random();
        logic [15:0] el, er;
        logic ok;
        int len;
        for (int r = 0; r < 6; r++) begin
            len = (r % 3 == 2) ? int'($urandom_range(3, 5)) : 4;
            for (int k = 0; k < 4; k++) rom4[k] = 16'($urandom);
            for (int k = 0; k < len; k++) begin sl[k] = 16'($urandom); sr[k] = 16'($urandom); end
            model_run(1'b0, len, el, er, ok);
            drive_run(1'b0, len);
            n_cmp++; if ((ok && (nv !== 1 || v_cyc !== len + 3 || ne !== 0)) || (!ok && (ne !== 1 || nv !== 0))) begin n_bad++;
                $display("FAIL rand%0d_strobe: len=%0d got vld n=%0d@%0d err n=%0d, want %s at %0d", r, len, nv, v_cyc, ne, ok ? "vld" : "err", len + 3); end
            n_cmp++; if (o_l !== el || o_r !== er) begin n_bad++;
                $display("FAIL rand%0d_result: len=%0d got l=%h r=%h, want l=%h r=%h", r, len, o_l, o_r, el, er); end
            hold_l[0] = el; hold_r[0] = er;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] el, er;
        logic ok;
        int bad_addr;
        for (int k = 0; k < 1024; k++) romb[k] = 16'($urandom);
        romb[0] = 16'h4000;
        for (int run = 0; run < 2; run++) begin
            for (int k = 0; k < 1021; k++) begin
                sl[k] = (run == 0) ? ((k == 0) ? 16'h7FFF : 16'h0000) : 16'($urandom);
                sr[k] = 16'($urandom);
            end
            model_run(1'b1, 1021, el, er, ok);
            drive_run(1'b1, 1021);
            n_cmp++; if (nv !== 1 || v_cyc !== 1024 || ne !== 0) begin n_bad++;
                $display("FAIL b2b%0d_vld: got vld cycle %0d n=%0d err n=%0d, want cycle 1024 once", run, v_cyc, nv, ne); end
            n_cmp++; if (o_l !== el || o_r !== er) begin n_bad++;
                $display("FAIL b2b%0d_result: got l=%h r=%h, want l=%h r=%h", run, o_l, o_r, el, er); end
            bad_addr = 0;
            for (int k = 0; k < 1021; k++) if (p_addr[k] != k) bad_addr++;
            n_cmp++; if (bad_addr != 0 || addr_max > 1020 || addr_end != 0) begin n_bad++;
                $display("FAIL b2b%0d_addr: got %0d wrong addresses, max=%0d end=%0d, want 0, <=1020, 0", run, bad_addr, addr_max, addr_end); end
            if (run == 0) begin
                n_cmp++; if (o_l !== 16'h3FFF) begin n_bad++;
                    $display("FAIL impulse_left: got %h, want 3fff", o_l); end
            end
            hold_l[1] = el; hold_r[1] = er;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int k = 0; k < 4; k++) rom4[k] = '0;
        for (int k = 0; k < 1024; k++) romb[k] = '0;
        test_reset();
        test_basic("basic");
        test_saturate();
        test_bad_length("short", 3);
        test_bad_length("long", 6);
        test_reset_mid_run();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
